// File: rtl/cfg_axil_pkg.sv
// Shared types and constants for the configuration-path AXI-Lite master.
package cfg_axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WR_ADDR_DATA = 3'd1,
    ST_WR_RESP      = 3'd2,
    ST_RD_ADDR      = 3'd3,
    ST_RD_DATA      = 3'd4,
    ST_RESP         = 3'd5
  } cfg_axil_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Configure-block register map (byte offsets)
  localparam logic [31:0] REG_INIT_SEQ         = 32'h0000_0000;
  localparam logic [31:0] REG_SND_BUFFER_SIZE  = 32'h0000_0004;
  localparam logic [31:0] REG_REV_BUFFER_SIZE  = 32'h0000_0008;
  localparam logic [31:0] REG_FLIGHT_FLAG_SIZE = 32'h0000_000C;
  localparam logic [31:0] REG_MSS_SIZE         = 32'h0000_0010;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cfg_cmd_t;

  function automatic logic is_axi_state(cfg_axil_state_e s);
    return (s == ST_WR_ADDR_DATA) || (s == ST_WR_RESP) ||
           (s == ST_RD_ADDR)      || (s == ST_RD_DATA);
  endfunction

endpackage

// File: rtl/cfg_axil_watchdog.sv
// Saturating cycle counter with a sticky expiry flag; never aborts anything.
module cfg_axil_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] MAX = W'(LIMIT);

  logic [W-1:0] count;

  // expired is set on the same edge the count reaches MAX
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != MAX) begin
      count <= count + 1'b1;
      if (count == MAX - 1'b1) expired <= 1'b1;
    end
  end

endmodule

// File: rtl/cfg_axil_master.sv
// Command/response to single AXI-Lite transaction bridge, one outstanding at a time.
module cfg_axil_master
  import cfg_axil_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        busy,
  output logic        timeout,
  output logic [31:0] ctrl_m_axi_awaddr,
  output logic        ctrl_m_axi_awvalid,
  input  logic        ctrl_m_axi_awready,
  output logic [31:0] ctrl_m_axi_wdata,
  output logic [3:0]  ctrl_m_axi_wstrb,
  output logic        ctrl_m_axi_wvalid,
  input  logic        ctrl_m_axi_wready,
  input  logic [1:0]  ctrl_m_axi_bresp,
  input  logic        ctrl_m_axi_bvalid,
  output logic        ctrl_m_axi_bready,
  output logic [31:0] ctrl_m_axi_araddr,
  output logic        ctrl_m_axi_arvalid,
  input  logic        ctrl_m_axi_arready,
  input  logic [31:0] ctrl_m_axi_rdata,
  input  logic [1:0]  ctrl_m_axi_rresp,
  input  logic        ctrl_m_axi_rvalid,
  output logic        ctrl_m_axi_rready
);

  cfg_axil_state_e state;
  cfg_cmd_t        cmd_q;
  logic            awvalid_q, wvalid_q, arvalid_q;
  logic            aw_done, w_done;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign rsp_valid = (state == ST_RESP);

  assign ctrl_m_axi_awaddr  = cmd_q.addr;
  assign ctrl_m_axi_araddr  = cmd_q.addr;
  assign ctrl_m_axi_wdata   = cmd_q.wdata;
  assign ctrl_m_axi_wstrb   = cmd_q.wstrb;
  assign ctrl_m_axi_awvalid = awvalid_q;
  assign ctrl_m_axi_wvalid  = wvalid_q;
  assign ctrl_m_axi_arvalid = arvalid_q;
  assign ctrl_m_axi_bready  = (state == ST_WR_RESP);
  assign ctrl_m_axi_rready  = (state == ST_RD_DATA);

  // A channel counts as done once it has handshaken, now or earlier
  assign aw_done = !awvalid_q || ctrl_m_axi_awready;
  assign w_done  = !wvalid_q  || ctrl_m_axi_wready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cmd_q     <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (cmd_valid) begin
          cmd_q <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata, wstrb: cmd_wstrb};
          if (cmd_write) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state     <= ST_WR_ADDR_DATA;
          end else begin
            arvalid_q <= 1'b1;
            state     <= ST_RD_ADDR;
          end
        end
        ST_WR_ADDR_DATA: begin
          if (ctrl_m_axi_awready) awvalid_q <= 1'b0;
          if (ctrl_m_axi_wready)  wvalid_q  <= 1'b0;
          if (aw_done && w_done)  state     <= ST_WR_RESP;
        end
        ST_WR_RESP: if (ctrl_m_axi_bvalid) begin
          rsp_write <= 1'b1;
          rsp_rdata <= '0;
          rsp_resp  <= ctrl_m_axi_bresp;
          state     <= ST_RESP;
        end
        ST_RD_ADDR: if (ctrl_m_axi_arready) begin
          arvalid_q <= 1'b0;
          state     <= ST_RD_DATA;
        end
        ST_RD_DATA: if (ctrl_m_axi_rvalid) begin
          rsp_write <= 1'b0;
          rsp_rdata <= ctrl_m_axi_rdata;
          rsp_resp  <= ctrl_m_axi_rresp;
          state     <= ST_RESP;
        end
        ST_RESP: if (rsp_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  cfg_axil_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cmd_valid && cmd_ready),
    .enable  (is_axi_state(state)),
    .expired (timeout)
  );

endmodule

// File: tb/tb_cfg_axil_master.sv
// Randomized bench: behavioural AXI-Lite slave plus a register-array reference model.
module tb_cfg_axil_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy, timeout;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  cfg_axil_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy), .timeout(timeout),
    .ctrl_m_axi_awaddr(awaddr), .ctrl_m_axi_awvalid(awvalid), .ctrl_m_axi_awready(awready),
    .ctrl_m_axi_wdata(wdata), .ctrl_m_axi_wstrb(wstrb), .ctrl_m_axi_wvalid(wvalid),
    .ctrl_m_axi_wready(wready), .ctrl_m_axi_bresp(bresp), .ctrl_m_axi_bvalid(bvalid),
    .ctrl_m_axi_bready(bready), .ctrl_m_axi_araddr(araddr), .ctrl_m_axi_arvalid(arvalid),
    .ctrl_m_axi_arready(arready), .ctrl_m_axi_rdata(rdata), .ctrl_m_axi_rresp(rresp),
    .ctrl_m_axi_rvalid(rvalid), .ctrl_m_axi_rready(rready)
  );

  // ---- slave knobs and state ----
  int          aw_dly = 0, w_dly = 0, ar_dly = 0;
  bit          b_hold = 1'b0;
  logic [1:0]  err_resp = 2'b00;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  int          cyc = 0, aw_cyc = 0, w_cyc = 0, ar_cyc = 0, b_hs_cnt = 0;
  logic        aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0;
  logic [31:0] got_awaddr = '0, got_wdata = '0, got_araddr = '0;
  logic [3:0]  got_wstrb = '0;
  logic [31:0] mem [16];
  logic        aw_hs, w_hs, ar_hs;
  logic [31:0] a_eff, d_eff;
  logic [3:0]  s_eff;

  assign awready = awvalid && (aw_cnt >= aw_dly);
  assign wready  = wvalid  && (w_cnt  >= w_dly);
  assign arready = arvalid && (ar_cnt >= ar_dly);
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign ar_hs   = arvalid && arready;
  assign a_eff   = aw_hs ? awaddr : got_awaddr;
  assign d_eff   = w_hs ? wdata : got_wdata;
  assign s_eff   = w_hs ? wstrb : got_wstrb;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (awvalid) aw_cyc <= aw_cyc + 1;
      if (wvalid)  w_cyc  <= w_cyc + 1;
      if (arvalid) ar_cyc <= ar_cyc + 1;
      if (aw_hs) begin aw_got <= 1'b1; aw_cnt <= 0; got_awaddr <= awaddr; end
      else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (w_hs) begin w_got <= 1'b1; w_cnt <= 0; got_wdata <= wdata; got_wstrb <= wstrb; end
      else if (wvalid) w_cnt <= w_cnt + 1;
      if (bvalid && bready) begin bvalid <= 1'b0; b_hs_cnt <= b_hs_cnt + 1; end
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        for (int b = 0; b < 4; b++)
          if (s_eff[b]) mem[a_eff[5:2]][8*b +: 8] <= d_eff[8*b +: 8];
        aw_got <= 1'b0; w_got <= 1'b0;
        bresp  <= err_resp;
        bvalid <= !b_hold;
        b_pend <= b_hold;
      end else if (b_pend && !b_hold) begin
        bvalid <= 1'b1; b_pend <= 1'b0;
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (ar_hs) begin
        ar_cnt <= 0; got_araddr <= araddr;
        rvalid <= 1'b1; rdata <= mem[araddr[5:2]]; rresp <= err_resp;
      end else if (arvalid) ar_cnt <= ar_cnt + 1;
    end
  end

  // ---- reference model ----
  int          checks = 0, failures = 0;
  logic [31:0] ref_mem [16];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int stall,
                         output logic [31:0] rd, output logic [1:0] rr, output logic rw,
                         output int lat, output bit stable, output int acc);
    acc = cyc;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 200) begin
      // junk offered while busy must be ignored
      cmd_valid = 1'($urandom_range(0, 1)); cmd_write = 1'($urandom_range(0, 1));
      cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
      @(negedge clk); lat++;
    end
    cmd_valid = 1'b0;
    if (lat >= 200) begin
      checks++; failures++;
      $display("FAIL rsp_wait_bound: no rsp_valid after %0d cycles", lat);
    end
    rd = rsp_rdata; rr = rsp_resp; rw = rsp_write; stable = 1'b1;
    repeat (stall) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_resp !== rr || rsp_write !== rw)
        stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0) begin
      failures++; $display("FAIL reset_valids got=%b want=000000", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b want=0", timeout); end
    checks++; if ({awaddr, araddr, wdata, wstrb} !== 100'b0) begin
      failures++; $display("FAIL reset_axi_payload got=%h want=0", {awaddr, araddr, wdata, wstrb}); end
    checks++; if ({rsp_write, rsp_rdata, rsp_resp} !== 35'b0) begin
      failures++; $display("FAIL reset_rsp_payload got=%h want=0", {rsp_write, rsp_rdata, rsp_resp}); end
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    logic [31:0] rd; logic [1:0] rr; logic rw; int lat, acc; bit st;
    run_cmd(1'b1, 32'h04, 32'h0000_1000, 4'hF, 0, rd, rr, rw, lat, st, acc);
    ref_mem[1] = merge(ref_mem[1], 32'h0000_1000, 4'hF);
    checks++; if (lat != 3) begin failures++; $display("FAIL wr_latency got=%0d want=3", lat); end
    checks++; if (rr !== 2'b00 || rd !== 32'h0 || rw !== 1'b1) begin
      failures++; $display("FAIL wr_rsp got resp=%b rdata=%h write=%b want 00/0/1", rr, rd, rw); end
    checks++; if (mem[1] !== 32'h0000_1000) begin failures++; $display("FAIL wr_snd_buffer_size got=%h want=00001000", mem[1]); end
    run_cmd(1'b0, 32'h04, 32'hDEAD_BEEF, 4'h0, 2, rd, rr, rw, lat, st, acc);
    checks++; if (rd !== ref_mem[1] || rr !== 2'b00 || rw !== 1'b0) begin
      failures++; $display("FAIL rd_rsp got rdata=%h resp=%b write=%b want %h/00/0", rd, rr, rw, ref_mem[1]); end
    checks++; if (lat != 3 || !st) begin failures++; $display("FAIL rd_latency_stable got lat=%0d stable=%0d want 3/1", lat, st); end
  endtask

  task automatic test_wready_lag;
    logic [31:0] rd, d; logic [1:0] rr; logic rw; int lat, acc, aw0, w0, b0; bit st;
    w_dly = 3; d = $urandom;
    aw0 = aw_cyc; w0 = w_cyc; b0 = b_hs_cnt;
    run_cmd(1'b1, 32'h08, d, 4'hF, 0, rd, rr, rw, lat, st, acc);
    ref_mem[2] = merge(ref_mem[2], d, 4'hF);
    checks++; if (aw_cyc - aw0 != 1) begin failures++; $display("FAIL lag_awvalid_cycles got=%0d want=1", aw_cyc - aw0); end
    checks++; if (w_cyc - w0 != 4) begin failures++; $display("FAIL lag_wvalid_cycles got=%0d want=4", w_cyc - w0); end
    checks++; if (b_hs_cnt - b0 != 1) begin failures++; $display("FAIL lag_b_count got=%0d want=1", b_hs_cnt - b0); end
    checks++; if (lat != 6 || mem[2] !== ref_mem[2]) begin
      failures++; $display("FAIL lag_result got lat=%0d mem=%h want 6/%h", lat, mem[2], ref_mem[2]); end
    w_dly = 0;
  endtask

  task automatic test_slverr;
    logic [31:0] rd; logic [1:0] rr; logic rw; int lat, acc; bit st;
    err_resp = 2'b10;
    run_cmd(1'b1, 32'h0C, 32'h0000_0040, 4'h3, 1, rd, rr, rw, lat, st, acc);
    ref_mem[3] = merge(ref_mem[3], 32'h0000_0040, 4'h3);
    checks++; if (rr !== 2'b10 || rd !== 32'h0) begin failures++; $display("FAIL slverr_resp got=%b rdata=%h want 10/0", rr, rd); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL slverr_timeout got=%b want=0", timeout); end
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL slverr_idle got busy=%b cmd_ready=%b want 0/1", busy, cmd_ready); end
    err_resp = 2'b11;
    run_cmd(1'b0, 32'h0C, 32'h0, 4'h0, 0, rd, rr, rw, lat, st, acc);
    checks++; if (rr !== 2'b11 || rd !== ref_mem[3]) begin
      failures++; $display("FAIL decerr_read got resp=%b rdata=%h want 11/%h", rr, rd, ref_mem[3]); end
    err_resp = 2'b00;
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd, a, d; logic [1:0] rr; logic rw, w; int lat, acc, prev; bit st;
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      w = (i % 2 == 0); a = 32'h10 + 32'(i * 4); d = $urandom;
      run_cmd(w, a, d, 4'hF, 0, rd, rr, rw, lat, st, acc);
      if (w) ref_mem[a[5:2]] = merge(ref_mem[a[5:2]], d, 4'hF);
      checks++; if (rd !== (w ? 32'h0 : ref_mem[a[5:2]]) || rr !== 2'b00 || rw !== w) begin
        failures++; $display("FAIL b2b_rsp[%0d] got rdata=%h resp=%b write=%b", i, rd, rr, rw); end
      if (prev >= 0) begin
        checks++; if (acc - prev != 4) begin failures++; $display("FAIL b2b_spacing[%0d] got=%0d want=4", i, acc - prev); end
      end
      prev = acc;
    end
  endtask

  task automatic test_random;
    logic [31:0] rd, a, d, exp_rd; logic [3:0] s; logic [1:0] rr, er; logic rw, w;
    int lat, acc, stall, exp_lat, bad; bit st;
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
      er = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
      err_resp = er;
      w = 1'($urandom_range(0, 1)); a = $urandom & 32'hFFFF_FFFC; d = $urandom;
      s = 4'($urandom); stall = $urandom_range(0, 2);
      exp_lat = w ? ((aw_dly > w_dly ? aw_dly : w_dly) + 3) : (ar_dly + 3);
      exp_rd  = w ? 32'h0 : ref_mem[a[5:2]];
      run_cmd(w, a, d, s, stall, rd, rr, rw, lat, st, acc);
      if (w) ref_mem[a[5:2]] = merge(ref_mem[a[5:2]], d, s);
      checks++;
      if (rd !== exp_rd || rr !== er || rw !== w || lat != exp_lat || !st) begin
        failures++;
        $display("FAIL rand_rsp[%0d] got rdata=%h resp=%b write=%b lat=%0d stable=%0d want %h/%b/%b/%0d/1",
                 i, rd, rr, rw, lat, st, exp_rd, er, w, exp_lat);
      end
      if (w && (got_awaddr !== a || got_wdata !== d || got_wstrb !== s)) bad++;
      if (!w && got_araddr !== a) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL rand_axi_payload got=%0d bad want=0", bad); end
    checks++; for (int i = 0; i < 16; i++) if (mem[i] !== ref_mem[i]) bad++;
    if (bad != 0) begin failures++; $display("FAIL rand_mem_image got=%0d bad want=0", bad); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL rand_timeout got=%b want=0", timeout); end
    aw_dly = 0; w_dly = 0; ar_dly = 0; err_resp = 2'b00;
  endtask

  task automatic test_timeout;
    int k, rise, ar0; bit dropped;
    ar_dly = 20; ar0 = ar_cyc; rise = -1; dropped = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h04;
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 1;
    while (rsp_valid !== 1'b1 && k < 200) begin
      if (timeout === 1'b1 && rise < 0) rise = k;
      if (rise >= 0 && timeout !== 1'b1) dropped = 1'b1;
      @(negedge clk); k++;
    end
    checks++; if (rise != 9) begin failures++; $display("FAIL to_rise_cycle got=%0d want=9", rise); end
    checks++; if (dropped) begin failures++; $display("FAIL to_sticky got dropped=1 want=0"); end
    checks++; if (ar_cyc - ar0 != 21) begin failures++; $display("FAIL to_arvalid_cycles got=%0d want=21", ar_cyc - ar0); end
    checks++; if (k != 23 || rsp_rdata !== ref_mem[1] || rsp_resp !== 2'b00 || rsp_write !== 1'b0) begin
      failures++; $display("FAIL to_read_result got k=%0d rdata=%h resp=%b write=%b want 23/%h/00/0",
                           k, rsp_rdata, rsp_resp, rsp_write, ref_mem[1]); end
    rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
    checks++; if (timeout !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL to_after got timeout=%b busy=%b want 1/0", timeout, busy); end
    ar_dly = 0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic [1:0] rr; logic rw; int lat, acc, k; bit st;
    b_hold = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h04; cmd_wdata = 32'h55; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 0;
    while (bready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    checks++; if (bready !== 1'b1) begin failures++; $display("FAIL mid_reach_wr_resp got bready=%b want=1", bready); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0) begin
      failures++; $display("FAIL mid_valids got=%b want=000000", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}); end
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || timeout !== 1'b0) begin
      failures++; $display("FAIL mid_idle got cmd_ready=%b busy=%b timeout=%b want 1/0/0", cmd_ready, busy, timeout); end
    rst_n = 1'b1; b_hold = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    @(negedge clk);
    run_cmd(1'b0, 32'h04, 32'h0, 4'h0, 0, rd, rr, rw, lat, st, acc);
    checks++; if (rd !== ref_mem[1] || rr !== 2'b00 || rw !== 1'b0 || lat != 3) begin
      failures++; $display("FAIL mid_read_after got rdata=%h resp=%b write=%b lat=%0d want %h/00/0/3", rd, rr, rw, lat, ref_mem[1]); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wready_lag();
    test_slverr();
    test_back_to_back();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
